// File: rtl/hbi_rd_seq_pkg.sv
// ============================================================================
// hbi_rd_seq_pkg : shared types and constants for the HBI read-beat sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package hbi_rd_seq_pkg;

  localparam int LAT_W = 8;
  localparam int SEL_W = 3;

  localparam int INIT_LAT_DEF = 16;
  localparam int SUB_LAT_DEF  = 8;

  localparam logic [SEL_W-1:0] SRC_PERPH = 3'd0;
  localparam logic [SEL_W-1:0] SRC_CRT   = 3'd1;
  localparam logic [SEL_W-1:0] SRC_HBI   = 3'd2;
  localparam logic [SEL_W-1:0] SRC_RC    = 3'd3;
  localparam logic [SEL_W-1:0] SRC_2DC   = 3'd4;
  localparam logic [SEL_W-1:0] SRC_DE    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOPW = 3'd3,
    ST_TURN  = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/hbi_lat_timer.sv
// ============================================================================
// hbi_lat_timer : latency counter with loadable limit and terminal-count flag
// Rev 1.0
// ============================================================================
`default_nettype none

module hbi_lat_timer
  import hbi_rd_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LAT_W-1:0] limit,
  input  logic             clr,
  input  logic             inc,
  output logic             tc
);

  localparam logic [LAT_W-1:0] ONE = 1;

  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [LAT_W-1:0] limit_q, limit_d;

  always_comb begin
    limit_d = load ? limit : limit_q;
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Flags the clock whose increment lands the count on limit-1.
  assign tc = (cnt_q + ONE) >= (limit_q - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      limit_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hbi_rd_seq.sv
// ============================================================================
// hbi_rd_seq : PCI target read-beat sequencer for the host bus output stage
// Rev 1.0
// ============================================================================
`default_nettype none

module hbi_rd_seq
  import hbi_rd_seq_pkg::*;
#(
  parameter int NSRC     = 6,
  parameter int INIT_LAT = INIT_LAT_DEF,
  parameter int SUB_LAT  = SUB_LAT_DEF
) (
  input  logic             hb_clk,
  input  logic             sys_reset_n,
  input  logic             rd_start,
  input  logic [SEL_W-1:0] src_sel,
  input  logic [NSRC-1:0]  src_rdy,
  input  logic             burst_ok,
  input  logic             frame_n,
  input  logic             irdy_n,
  output logic             devsel_n,
  output logic             trdy_n,
  output logic             stop_n,
  output logic             ad_oe,
  output logic             any_trdy_async,
  output logic [NSRC-1:0]  src_ack,
  output logic [7:0]       beat_cnt
);

  localparam logic [LAT_W-1:0] INIT_LIM = LAT_W'(INIT_LAT);
  localparam logic [LAT_W-1:0] SUB_LIM  = LAT_W'(SUB_LAT);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             devsel_n_q, devsel_n_d;
  logic             trdy_n_q, trdy_n_d;
  logic             stop_n_q, stop_n_d;
  logic             ad_oe_q, ad_oe_d;
  logic [NSRC-1:0]  src_ack_q, src_ack_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;

  logic             sel_rdy;
  logic             lat_clr;
  logic             lat_inc;
  logic             lat_tc;
  logic [LAT_W-1:0] lat_limit;

  assign sel_rdy        = src_rdy[sel_q];
  assign any_trdy_async = ((state_q == ST_WAIT) || (state_q == ST_DATA)) && sel_rdy;

  // First beat is bounded by the initial latency, later beats by the subsequent one.
  assign lat_limit = (beat_cnt_d == '0) ? INIT_LIM : SUB_LIM;

  hbi_lat_timer u_lat_timer (
    .clk   (hb_clk),
    .rst_n (sys_reset_n),
    .load  (lat_clr),
    .limit (lat_limit),
    .clr   (lat_clr),
    .inc   (lat_inc),
    .tc    (lat_tc)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    devsel_n_d = devsel_n_q;
    trdy_n_d   = trdy_n_q;
    stop_n_d   = stop_n_q;
    ad_oe_d    = ad_oe_q;
    src_ack_d  = '0;
    beat_cnt_d = beat_cnt_q;
    lat_clr    = 1'b0;
    lat_inc    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rd_start) begin
          sel_d      = (int'(src_sel) >= NSRC) ? SRC_DE : src_sel;
          beat_cnt_d = '0;
          lat_clr    = 1'b1;
          devsel_n_d = 1'b0;
          trdy_n_d   = 1'b1;
          stop_n_d   = 1'b1;
          ad_oe_d    = 1'b0;
          state_d    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        lat_inc = 1'b1;
        ad_oe_d = 1'b1;
        if (sel_rdy) begin
          trdy_n_d = 1'b0;
          state_d  = ST_DATA;
        end else if (lat_tc) begin
          stop_n_d = 1'b0;
          state_d  = ST_STOPW;
        end
      end

      ST_DATA: begin
        if (!irdy_n) begin
          src_ack_d[sel_q] = 1'b1;
          beat_cnt_d       = (beat_cnt_q == 8'hFF) ? beat_cnt_q : beat_cnt_q + 8'd1;
          lat_clr          = 1'b1;
          if (frame_n) begin
            trdy_n_d   = 1'b1;
            devsel_n_d = 1'b1;
            stop_n_d   = 1'b1;
            ad_oe_d    = 1'b0;
            state_d    = ST_TURN;
          end else if (!(burst_ok && sel_rdy)) begin
            trdy_n_d = 1'b1;
            if (!burst_ok) begin
              stop_n_d = 1'b0;
              state_d  = ST_STOPW;
            end else begin
              state_d  = ST_WAIT;
            end
          end
        end
      end

      ST_STOPW: begin
        if (frame_n) begin
          devsel_n_d = 1'b1;
          stop_n_d   = 1'b1;
          trdy_n_d   = 1'b1;
          ad_oe_d    = 1'b0;
          state_d    = ST_TURN;
        end
      end

      ST_TURN: begin
        state_d = ST_IDLE;
      end

      default: begin
        devsel_n_d = 1'b1;
        trdy_n_d   = 1'b1;
        stop_n_d   = 1'b1;
        ad_oe_d    = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge hb_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      devsel_n_q <= 1'b1;
      trdy_n_q   <= 1'b1;
      stop_n_q   <= 1'b1;
      ad_oe_q    <= 1'b0;
      src_ack_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      devsel_n_q <= devsel_n_d;
      trdy_n_q   <= trdy_n_d;
      stop_n_q   <= stop_n_d;
      ad_oe_q    <= ad_oe_d;
      src_ack_q  <= src_ack_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign devsel_n = devsel_n_q;
  assign trdy_n   = trdy_n_q;
  assign stop_n   = stop_n_q;
  assign ad_oe    = ad_oe_q;
  assign src_ack  = src_ack_q;
  assign beat_cnt = beat_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hbi_rd_seq.sv
// ============================================================================
// tb_hbi_rd_seq : self-checking bench for hbi_rd_seq with an ack scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hbi_rd_seq;

  logic       hb_clk = 1'b0;
  logic       sys_reset_n;
  logic       rd_start;
  logic [2:0] src_sel;
  logic [5:0] src_rdy;
  logic       burst_ok;
  logic       frame_n;
  logic       irdy_n;
  logic       devsel_n;
  logic       trdy_n;
  logic       stop_n;
  logic       ad_oe;
  logic       any_trdy_async;
  logic [5:0] src_ack;
  logic [7:0] beat_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int sb_q[$];

  always #5 hb_clk = ~hb_clk;

  hbi_rd_seq #(
    .NSRC     (6),
    .INIT_LAT (16),
    .SUB_LAT  (8)
  ) dut (
    .hb_clk         (hb_clk),
    .sys_reset_n    (sys_reset_n),
    .rd_start       (rd_start),
    .src_sel        (src_sel),
    .src_rdy        (src_rdy),
    .burst_ok       (burst_ok),
    .frame_n        (frame_n),
    .irdy_n         (irdy_n),
    .devsel_n       (devsel_n),
    .trdy_n         (trdy_n),
    .stop_n         (stop_n),
    .ad_oe          (ad_oe),
    .any_trdy_async (any_trdy_async),
    .src_ack        (src_ack),
    .beat_cnt       (beat_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge hb_clk);
    #1;
  endtask

  // Every observed ack pulse must match the next expected source.
  always @(negedge hb_clk) begin
    if (src_ack != 6'd0) begin
      if (sb_q.size() == 0) begin
        chk("spurious_ack", 32'(src_ack), 32'd0);
      end else begin
        logic [5:0] exp_oh;
        exp_oh = 6'd1 << sb_q.pop_front();
        chk("sb_ack", 32'(src_ack), 32'(exp_oh));
      end
    end
  end

  initial begin
    rd_start = 1'b0; src_sel = 3'd0; src_rdy = 6'd0; burst_ok = 1'b0;
    frame_n = 1'b1; irdy_n = 1'b1; sys_reset_n = 1'b1;
    #2 sys_reset_n = 1'b0;
    #1;
    chk("rst_devsel", 32'(devsel_n), 32'd1);
    chk("rst_trdy",   32'(trdy_n),   32'd1);
    chk("rst_stop",   32'(stop_n),   32'd1);
    chk("rst_adoe",   32'(ad_oe),    32'd0);
    chk("rst_ack",    32'(src_ack),  32'd0);
    chk("rst_beat",   32'(beat_cnt), 32'd0);
    repeat (2) @(posedge hb_clk);
    #2 sys_reset_n = 1'b1;
    step();

    // single read, source 2 ready at once
    src_sel = 3'd2; src_rdy = 6'b000100; irdy_n = 1'b0; frame_n = 1'b1; rd_start = 1'b1;
    sb_q.push_back(2);
    step(); rd_start = 1'b0;
    chk("t1_devsel_c1", 32'(devsel_n), 32'd0);
    chk("t1_trdy_c1",   32'(trdy_n),   32'd1);
    chk("t1_any_c1",    32'(any_trdy_async), 32'd1);
    step();
    chk("t1_trdy_c2",   32'(trdy_n), 32'd0);
    chk("t1_adoe_c2",   32'(ad_oe),  32'd1);
    step();
    chk("t1_trdy_turn",   32'(trdy_n),   32'd1);
    chk("t1_devsel_turn", 32'(devsel_n), 32'd1);
    chk("t1_adoe_turn",   32'(ad_oe),    32'd0);
    chk("t1_beat",        32'(beat_cnt), 32'd1);
    chk("t1_ack",         32'(src_ack),  32'h4);
    step();
    chk("t1_idle_any", 32'(any_trdy_async), 32'd0);
    chk("t1_ack_off",  32'(src_ack), 32'd0);
    irdy_n = 1'b1; src_rdy = 6'd0;

    // source 3 never ready: retry at the initial-latency boundary
    src_sel = 3'd3; frame_n = 1'b0; irdy_n = 1'b0; rd_start = 1'b1;
    step(); rd_start = 1'b0;
    for (int k = 2; k <= 16; k++) begin
      step();
      chk("t2_stop", 32'(stop_n), (k == 16) ? 32'd0 : 32'd1);
      chk("t2_trdy", 32'(trdy_n), 32'd1);
    end
    step(); step();
    chk("t2_stop_hold",   32'(stop_n),   32'd0);
    chk("t2_devsel_hold", 32'(devsel_n), 32'd0);
    frame_n = 1'b1;
    step();
    chk("t2_turn_stop",   32'(stop_n),   32'd1);
    chk("t2_turn_devsel", 32'(devsel_n), 32'd1);
    chk("t2_turn_adoe",   32'(ad_oe),    32'd0);
    step();
    chk("t2_beat", 32'(beat_cnt), 32'd0);

    // 4-beat burst from source 4 with a 2-clock irdy stall on beat 2
    src_sel = 3'd4; src_rdy = 6'b010000; burst_ok = 1'b1; frame_n = 1'b0; irdy_n = 1'b0;
    rd_start = 1'b1;
    repeat (4) sb_q.push_back(4);
    step(); rd_start = 1'b0;
    step();
    chk("t3_trdy_first", 32'(trdy_n), 32'd0);
    step();
    chk("t3_beat1", 32'(beat_cnt), 32'd1);
    irdy_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("t3_stall_trdy", 32'(trdy_n),   32'd0);
      chk("t3_stall_beat", 32'(beat_cnt), 32'd1);
    end
    irdy_n = 1'b0;
    step();
    chk("t3_beat2", 32'(beat_cnt), 32'd2);
    step();
    frame_n = 1'b1;
    step();
    chk("t3_beat4",      32'(beat_cnt), 32'd4);
    chk("t3_trdy_end",   32'(trdy_n),   32'd1);
    chk("t3_devsel_end", 32'(devsel_n), 32'd1);
    step();
    burst_ok = 1'b0;

    // source 1 drops ready after beat 1: disconnect at the subsequent-latency boundary
    src_sel = 3'd1; src_rdy = 6'b000010; burst_ok = 1'b1; frame_n = 1'b0; irdy_n = 1'b0;
    rd_start = 1'b1;
    sb_q.push_back(1);
    step(); rd_start = 1'b0;
    step();
    src_rdy = 6'd0;
    step();
    chk("t4_trdy_wait", 32'(trdy_n),   32'd1);
    chk("t4_beat",      32'(beat_cnt), 32'd1);
    for (int k = 4; k <= 10; k++) begin
      step();
      chk("t4_stop", 32'(stop_n), (k == 10) ? 32'd0 : 32'd1);
    end
    src_rdy = 6'b000010;
    step();
    chk("t4_any_stopw", 32'(any_trdy_async), 32'd0);
    chk("t4_trdy_stopw", 32'(trdy_n), 32'd1);
    chk("t4_beat_end",  32'(beat_cnt), 32'd1);
    frame_n = 1'b1;
    step(); step();
    src_rdy = 6'd0; burst_ok = 1'b0;

    // ready arrives on the same clock the initial limit is reached: ready wins
    src_sel = 3'd0; frame_n = 1'b1; irdy_n = 1'b0; rd_start = 1'b1;
    sb_q.push_back(0);
    step(); rd_start = 1'b0;
    for (int k = 2; k <= 15; k++) step();
    src_rdy = 6'b000001;
    step();
    chk("t5_trdy_win", 32'(trdy_n), 32'd0);
    chk("t5_stop_win", 32'(stop_n), 32'd1);
    step();
    chk("t5_beat", 32'(beat_cnt), 32'd1);
    step();
    src_rdy = 6'd0;

    // burst_ok=0, out-of-range select maps to DE regs
    src_sel = 3'd7; src_rdy = 6'b100000; burst_ok = 1'b0; frame_n = 1'b0; irdy_n = 1'b0;
    rd_start = 1'b1;
    sb_q.push_back(5);
    step(); rd_start = 1'b0;
    step();
    step();
    chk("t6_stop",  32'(stop_n),   32'd0);
    chk("t6_trdy",  32'(trdy_n),   32'd1);
    chk("t6_beat",  32'(beat_cnt), 32'd1);
    step(); step();
    chk("t6_stop_hold", 32'(stop_n),   32'd0);
    chk("t6_beat_hold", 32'(beat_cnt), 32'd1);
    frame_n = 1'b1;
    step(); step();

    // asynchronous reset in the middle of DATA
    src_sel = 3'd2; src_rdy = 6'b000100; burst_ok = 1'b1; frame_n = 1'b0; irdy_n = 1'b1;
    rd_start = 1'b1;
    step(); rd_start = 1'b0;
    step();
    chk("t7_trdy_data", 32'(trdy_n), 32'd0);
    #2 sys_reset_n = 1'b0;
    #1;
    chk("t7_rst_devsel", 32'(devsel_n), 32'd1);
    chk("t7_rst_trdy",   32'(trdy_n),   32'd1);
    chk("t7_rst_stop",   32'(stop_n),   32'd1);
    chk("t7_rst_adoe",   32'(ad_oe),    32'd0);
    irdy_n = 1'b0;
    @(posedge hb_clk);
    #2 sys_reset_n = 1'b1;
    step();
    chk("t7_idle_any",    32'(any_trdy_async), 32'd0);
    chk("t7_idle_devsel", 32'(devsel_n), 32'd1);
    chk("t7_idle_trdy",   32'(trdy_n),   32'd1);
    frame_n = 1'b1; src_rdy = 6'd0; irdy_n = 1'b1;
    step(); step();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
